// File: rtl/lfsr_chk_pkg.sv
// Shared definitions for the LFSR sequence checker.
//   chk_state_t : checker FSM states (HUNT, VERIFY, LOCKED)
//   lfsr4_next  : successor of a 4-bit value in the counter's LFSR sequence
//   LFSR_SEED   : counter seed, used as the period-measurement reference
//   PERIOD_W    : width of the period measurement
package lfsr_chk_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    localparam logic [3:0] LFSR_SEED = 4'b1001;
    localparam int         PERIOD_W  = 5;

    // Feedback Q3' = Q1^Q0, everything else shifts down by one.
    function automatic logic [3:0] lfsr4_next(input logic [3:0] x);
        return {x[1] ^ x[0], x[3], x[2], x[1]};
    endfunction

endpackage

// File: rtl/lfsr_period_meter.sv
// Period meter for the LFSR sequence checker.
// Counts valid samples while the checker is locked and latches the count
// between consecutive SEED samples. The first SEED after locking only arms
// the meter.
// Ports:
//   clk, reset (sync, active-low), clear (zeroes period/period_valid)
//   active       : checker currently in LOCKED
//   in_valid     : sample strobe
//   in_data[3:0] : sample
//   period[4:0], period_valid : last measurement
module lfsr_period_meter
    import lfsr_chk_pkg::*;
#(
    parameter logic [3:0] SEED = LFSR_SEED
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                active,
    input  logic                in_valid,
    input  logic [3:0]          in_data,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid
);

    logic [PERIOD_W-1:0] cnt;
    logic                armed;

    function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt          <= '0;
            armed        <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            if (clear) begin
                period       <= '0;
                period_valid <= 1'b0;
            end
            if (!active) begin
                // Leaving LOCKED forgets the previous SEED so a fresh lock
                // never reports a period spanning an unlocked stretch.
                armed <= 1'b0;
            end else if (in_valid) begin
                if (in_data == SEED) begin
                    if (armed) begin
                        period       <= cnt;
                        period_valid <= 1'b1;
                    end
                    armed <= 1'b1;
                    cnt   <= PERIOD_W'(1);
                end else begin
                    cnt <= sat_inc(cnt);
                end
            end
        end
    end

endmodule

// File: rtl/lfsr_seq_checker.sv
// Self-test monitor for the 4-bit LFSR counter. Locks onto the sample
// stream, then flywheels its own prediction and flags mismatches.
// Optional feature macro: LFSR_CHK_PERIOD_EN builds the period meter;
// without it period/period_valid are tied to 0.
// Ports:
//   clk, reset (sync, active-low)
//   in_valid, in_data[3:0] : counter samples
//   clear                  : zeroes err_count, stuck_zero, period, period_valid
//   locked                 : checker in LOCKED
//   err_pulse              : one-cycle pulse per mismatch while LOCKED
//   err_count[ERR_W-1:0]   : saturating mismatch count
//   stuck_zero             : sticky all-zero sample flag
//   period[4:0], period_valid : measured sequence period
module lfsr_seq_checker
    import lfsr_chk_pkg::*;
#(
    parameter int         LOCK_CNT   = 4,
    parameter int         UNLOCK_CNT = 3,
    parameter int         ERR_W      = 8,
    parameter logic [3:0] SEED       = LFSR_SEED
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [3:0]          in_data,
    input  logic                clear,
    output logic                locked,
    output logic                err_pulse,
    output logic [ERR_W-1:0]    err_count,
    output logic                stuck_zero,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid
);

    localparam logic [2:0] LOCK_R   = 3'(LOCK_CNT);
    localparam logic [2:0] UNLOCK_R = 3'(UNLOCK_CNT);

    chk_state_t state, state_n;
    logic [3:0] pred, pred_n;
    logic [2:0] run, run_n;
    logic [2:0] run_inc;
    logic       miss;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign run_inc = run + 3'd1;

    // Stage 0 -> registered state: FSM, prediction and run counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= HUNT;
            pred  <= 4'd0;
            run   <= 3'd0;
        end else begin
            state <= state_n;
            pred  <= pred_n;
            run   <= run_n;
        end
    end

    always_comb begin
        state_n = state;
        pred_n  = pred;
        run_n   = run;
        miss    = 1'b0;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (in_data != 4'd0) begin
                        pred_n  = lfsr4_next(in_data);
                        run_n   = 3'd0;
                        state_n = VERIFY;
                    end
                end
                VERIFY: begin
                    if (in_data == pred) begin
                        pred_n = lfsr4_next(in_data);
                        if (run_inc == LOCK_R) begin
                            state_n = LOCKED;
                            run_n   = 3'd0;
                        end else begin
                            run_n = run_inc;
                        end
                    end else if (in_data != 4'd0) begin
                        // Re-seed from the offending sample instead of
                        // dropping back to HUNT for a cycle.
                        pred_n = lfsr4_next(in_data);
                        run_n  = 3'd0;
                    end else begin
                        state_n = HUNT;
                        run_n   = 3'd0;
                    end
                end
                LOCKED: begin
                    // Flywheel: advance from our own prediction so one bad
                    // sample costs exactly one error.
                    pred_n = lfsr4_next(pred);
                    if (in_data == pred) begin
                        run_n = 3'd0;
                    end else begin
                        miss = 1'b1;
                        if (run_inc == UNLOCK_R) begin
                            state_n = HUNT;
                            run_n   = 3'd0;
                        end else begin
                            run_n = run_inc;
                        end
                    end
                end
                default: begin
                    state_n = HUNT;
                    run_n   = 3'd0;
                end
            endcase
        end
    end

    // Stage 0 -> registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            stuck_zero <= 1'b0;
        end else begin
            locked    <= (state_n == LOCKED);
            err_pulse <= miss;
            // Clear is applied before the increment of a same-cycle miss.
            if (clear) begin
                err_count <= miss ? ERR_W'(1) : '0;
            end else if (miss) begin
                err_count <= sat_inc(err_count);
            end
            if (in_valid && in_data == 4'd0) begin
                stuck_zero <= 1'b1;
            end else if (clear) begin
                stuck_zero <= 1'b0;
            end
        end
    end

`ifdef LFSR_CHK_PERIOD_EN
    lfsr_period_meter #(
        .SEED (SEED)
    ) u_period (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .active       (state == LOCKED),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .period       (period),
        .period_valid (period_valid)
    );
`else
    logic unused_seed;
    assign unused_seed  = ^SEED;
    assign period       = '0;
    assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_seq_checker.sv
module tb_lfsr_seq_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_data;
    logic       clear;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;
    logic       stuck_zero;
    logic [4:0] period;
    logic       period_valid;

    lfsr_seq_checker dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .clear        (clear),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .stuck_zero   (stuck_zero),
        .period       (period),
        .period_valid (period_valid)
    );

    always #5 clk = ~clk;

    // Counter sequence from the seed, written out by hand.
    logic [3:0] seq [15] = '{4'h9, 4'hC, 4'h6, 4'hB, 4'h5, 4'hA, 4'hD, 4'hE,
                             4'hF, 4'h7, 4'h3, 4'h1, 4'h8, 4'h4, 4'h2};

    typedef struct {
        int locked;
        int pulse;
        int errc;
        int stuck;
        int period;
        int pv;
    } exp_t;

    exp_t sbq[$];

    int checks   = 0;
    int failures = 0;
    int pos      = 0;

    // Reference model state
    int m_state, m_pred, m_run, m_locked, m_pulse, m_errc, m_stuck;
    int m_period, m_pv, m_pcnt, m_armed;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int tb_next(input int x);
        for (int i = 0; i < 15; i++)
            if (int'(seq[i]) == x) return int'(seq[(i + 1) % 15]);
        return 0;
    endfunction

    task automatic model(input logic rs, input logic v, input logic [3:0] d, input logic clr);
        int di;
        bit hit;
        di = int'(d);
        if (!rs) begin
            m_state = 0; m_pred = 0; m_run = 0; m_locked = 0; m_pulse = 0;
            m_errc = 0; m_stuck = 0; m_period = 0; m_pv = 0; m_pcnt = 0; m_armed = 0;
            return;
        end
        m_pulse = 0;
        if (clr) begin
            m_errc = 0; m_stuck = 0; m_period = 0; m_pv = 0;
        end
        if (v && di == 0) m_stuck = 1;
`ifdef LFSR_CHK_PERIOD_EN
        if (m_state != 2) m_armed = 0;
        else if (v) begin
            if (di == 9) begin
                if (m_armed != 0) begin
                    m_period = m_pcnt;
                    m_pv = 1;
                end
                m_armed = 1;
                m_pcnt = 1;
            end else if (m_pcnt < 31) m_pcnt++;
        end
`endif
        if (v) begin
            case (m_state)
                0: if (di != 0) begin
                    m_pred = tb_next(di); m_run = 0; m_state = 1;
                end
                1: if (di == m_pred) begin
                    m_pred = tb_next(di);
                    m_run++;
                    if (m_run == 4) begin m_state = 2; m_run = 0; end
                end else if (di != 0) begin
                    m_pred = tb_next(di); m_run = 0;
                end else begin
                    m_state = 0; m_run = 0;
                end
                default: begin
                    hit = (di == m_pred);
                    m_pred = tb_next(m_pred);
                    if (hit) m_run = 0;
                    else begin
                        m_pulse = 1;
                        if (m_errc < 255) m_errc++;
                        m_run++;
                        if (m_run == 3) begin m_state = 0; m_run = 0; end
                    end
                end
            endcase
        end
        m_locked = (m_state == 2) ? 1 : 0;
    endtask

    task automatic step(input logic rs, input logic v, input logic [3:0] d, input logic clr);
        exp_t e;
        reset = rs; in_valid = v; in_data = d; clear = clr;
        model(rs, v, d, clr);
        e.locked = m_locked; e.pulse = m_pulse; e.errc = m_errc;
        e.stuck = m_stuck; e.period = m_period; e.pv = m_pv;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("locked", int'(locked), e.locked);
        chk("err_pulse", int'(err_pulse), e.pulse);
        chk("err_count", int'(err_count), e.errc);
        chk("stuck_zero", int'(stuck_zero), e.stuck);
        chk("period", int'(period), e.period);
        chk("period_valid", int'(period_valid), e.pv);
    endtask

    task automatic good();
        step(1'b1, 1'b1, seq[pos % 15], 1'b0);
        pos++;
    endtask

    task automatic bad(input logic clr);
        step(1'b1, 1'b1, seq[(pos + 7) % 15], clr);
        pos++;
    endtask

    initial begin
        int exp_period;
`ifdef LFSR_CHK_PERIOD_EN
        exp_period = 15;
`else
        exp_period = 0;
`endif
        reset = 1'b0; in_valid = 1'b0; in_data = 4'd0; clear = 1'b0;
        step(1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b1, 4'h9, 1'b0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_err_count", int'(err_count), 0);

        // Lock from seed: locked after the 5th sample
        for (int i = 0; i < 4; i++) good();
        chk("not_locked_after4", int'(locked), 0);
        good();
        chk("locked_after5", int'(locked), 1);
        chk("no_err_at_lock", int'(err_count), 0);

        // Single corrupted sample 0101 -> 0111
        while (pos < 19) good();
        step(1'b1, 1'b1, 4'h7, 1'b0);
        pos++;
        chk("corrupt_pulse", int'(err_pulse), 1);
        chk("corrupt_count", int'(err_count), 1);
        chk("corrupt_locked", int'(locked), 1);
        good();
        chk("after_corrupt_pulse", int'(err_pulse), 0);
        chk("after_corrupt_count", int'(err_count), 1);

        // Two SEED occurrences while locked
        while (pos <= 30) good();
        chk("period_15", int'(period), exp_period);
        chk("period_valid", int'(period_valid), exp_period != 0 ? 1 : 0);

        // clear together with a mismatch
        bad(1'b1);
        chk("clear_and_miss", int'(err_count), 1);
        good();
        step(1'b1, 1'b0, 4'd0, 1'b1);
        chk("clear_idle", int'(err_count), 0);

        // Three consecutive misses drop the lock
        bad(1'b0);
        bad(1'b0);
        chk("locked_after2miss", int'(locked), 1);
        bad(1'b0);
        chk("unlock_count", int'(err_count), 3);
        chk("unlocked_after3", int'(locked), 0);
        for (int i = 0; i < 4; i++) good();
        chk("relock_not_yet", int'(locked), 0);
        good();
        chk("relock", int'(locked), 1);

        // Gap of 10 idle cycles mid-stream
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 4'h0, 1'b0);
        good();
        chk("gap_no_err", int'(err_pulse), 0);
        chk("gap_locked", int'(locked), 1);

        // Zero samples: sticky flag, FSM falls to and stays in HUNT
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 4'h0, 1'b0);
            pos++;
        end
        chk("stuck_set", int'(stuck_zero), 1);
        chk("zero_hunt", int'(locked), 0);
        step(1'b1, 1'b1, 4'h0, 1'b1);
        chk("clear_with_zero", int'(stuck_zero), 1);
        step(1'b1, 1'b0, 4'h0, 1'b1);
        chk("stuck_cleared", int'(stuck_zero), 0);

        // Reset pulse while locked
        for (int i = 0; i < 5; i++) good();
        chk("locked_before_rst", int'(locked), 1);
        step(1'b0, 1'b1, seq[pos % 15], 1'b0);
        pos++;
        chk("rst_mid_locked", int'(locked), 0);
        chk("rst_mid_errc", int'(err_count), 0);
        chk("rst_mid_period", int'(period), 0);
        for (int i = 0; i < 4; i++) good();
        chk("post_rst_4", int'(locked), 0);
        good();
        chk("post_rst_5", int'(locked), 1);
        for (int i = 0; i < 3; i++) good();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_seq_checker.md
# lfsr_seq_checker

Downstream monitor for the 4-bit override-seeded LFSR counter (taps Q3' = Q1^Q0, shift Q0'←Q1, Q1'←Q2, Q2'←Q3, seed 4'b1001, period 15). It samples the counter's `count` bus, locks onto the sequence, and flags deviations. It also flags the all-zero lock-up state and measures the sequence period. The block is the self-test stage placed directly after the counter in the Assignment 2 datapath.

## Interface
Parameters:
- `LOCK_CNT`, default 4: consecutive correct predictions required to assert `locked`.
- `UNLOCK_CNT`, default 3: consecutive mispredictions while locked that force a return to HUNT.
- `ERR_W`, default 8: width of the saturating error counter.
- `SEED`, default 4'b1001: reference value for period measurement.

Ports:
- `clk`, in, 1: rising-edge clock.
- `reset`, in, 1: reset, synchronous, active-low.
- `in_valid`, in, 1: `in_data` is a new counter sample this cycle.
- `in_data`, in, 4: counter value (`count[3:0]`).
- `clear`, in, 1: synchronous; zeroes `err_count`, `stuck_zero`, `period`, `period_valid`. FSM is unaffected.
- `locked`, out, 1: checker is in the LOCKED state.
- `err_pulse`, out, 1: one-cycle pulse per mismatch while LOCKED.
- `err_count`, out, ERR_W: saturating mismatch count.
- `stuck_zero`, out, 1: sticky; a valid sample equal to 4'b0000 was seen.
- `period`, out, 5: last measured number of valid samples between SEED occurrences.
- `period_valid`, out, 1: `period` holds a measurement.

## Operation
- `next(x)` = {x[1]^x[0], x[3], x[2], x[1]}, written as bits [3:0].
- Internal state: `pred` (4-bit), `run` (match/miss counter, 3 bits), FSM state.
- FSM states: HUNT, VERIFY, LOCKED. All transitions happen only on `in_valid`.
- HUNT:
  - Nonzero sample: `pred`←`next(in_data)`, `run`←0, go to VERIFY.
  - Zero sample: stay in HUNT.
- VERIFY:
  - Sample equals `pred`: `run`++ and `pred`←`next(in_data)`. When `run` reaches `LOCK_CNT`, go to LOCKED with `run`←0.
  - Mismatch: restart as if in HUNT using this sample (nonzero → stay in VERIFY with a fresh `pred` and `run`←0; zero → go to HUNT).
- LOCKED (flywheel mode):
  - `pred`←`next(pred)` on every valid sample, whether it matched or not.
  - Match: `run`←0.
  - Mismatch: `err_pulse` fires, `err_count`++ (saturates at all-ones), `run`++.
  - When `run` reaches `UNLOCK_CNT`, go to HUNT.
  - A single corrupted sample therefore yields exactly one error.
- `stuck_zero` sets on any valid 4'b0000 sample, in any state, and holds until `clear` or reset.
- Period measurement (LOCKED only):
  - A 5-bit sample counter counts valid samples.
  - On a valid sample equal to `SEED`: `period`←count since the previous SEED, `period_valid`←1, counter restarts at 1. The first SEED after entering LOCKED only arms the counter and does not update `period`.
  - The counter saturates at 31.
- Simultaneous events:
  - `clear` together with a mismatch: `err_count`←1 (clear first, then count).
  - `clear` together with a zero sample: `stuck_zero`←1.
  - `reset` dominates everything.

## Timing
- All outputs are registered.
- `err_pulse`, `err_count` and `stuck_zero` update in the cycle after the offending sample's `in_valid` edge.
- `locked` rises in the cycle after the `LOCK_CNT`-th consecutive match. With continuous valid samples that is sample index `LOCK_CNT` (0-based): the first sample only seeds `pred`.
- `locked` falls in the cycle after the `UNLOCK_CNT`-th consecutive miss.
- Reset values: state HUNT, `pred`=0, `run`=0, `locked`=0, `err_pulse`=0, `err_count`=0, `stuck_zero`=0, `period`=0, `period_valid`=0.
- Reset asserted mid-lock returns the block to HUNT on the next edge. Re-lock needs `LOCK_CNT`+1 valid samples.
- `in_valid`=0 freezes all state. Gaps between valid samples never count as errors.

## Configuration
- `LFSR_CHK_PERIOD_EN` defined: the period meter is built. `period` and `period_valid` behave as described above.
- Undefined: the meter logic is omitted, and `period` and `period_valid` are tied to 0.
- FSM, error counting and `stuck_zero` are identical in both builds.

## Structure
- Package `lfsr_chk_pkg`:
  - State enum {HUNT, VERIFY, LOCKED}.
  - `lfsr4_next()` function.
  - Default SEED constant 4'b1001.
  - Period width constant (5).
- Sub-module `lfsr_period_meter` holds the SEED detect, sample counter and `period` registers. It is instantiated only under `LFSR_CHK_PERIOD_EN`.

## Test plan
- Reset, then a continuous stream from seed: 1001, 1100, 0110, 1011, 0101, … → `locked`=1 in the cycle after the 5th sample, `err_count`=0.
- Locked, one sample replaced 0101→0111 → exactly one `err_pulse`, `err_count`=1, `locked` stays 1, next correct sample matches.
- Locked, 3 consecutive wrong samples → `err_count`=3, `locked`=0 in the cycle after the 3rd; resume the correct stream → re-lock after 5 samples.
- Locked with `LFSR_CHK_PERIOD_EN`, stream through two SEED occurrences → `period`=15, `period_valid`=1. Same run without the macro → `period`=0.
- Inject 0000 → `stuck_zero`=1, FSM stays in HUNT while the zeros repeat; `clear` → `stuck_zero`=0.
- `in_valid` low for 10 cycles mid-stream, then the correct next value → no error, `locked` held. Reset pulse while locked → all outputs return to their reset values.
